// File: rtl/vacc_if.sv
// Read/write sequencing bus between vacc_ctrl and the vacc datapath/BRAM.
// The master side drives the input stream; the slave side is the sequencer.
interface vacc_if #(
  parameter int VLB = 5
);
  logic           sync;
  logic           din_valid;
  logic           rd_en;
  logic [VLB-1:0] rd_addr;
  logic           rd_buf;
  logic           wr_en;
  logic [VLB-1:0] wr_addr;
  logic           wr_buf;
  logic           new_acc;

  modport master (
    output sync,
    output din_valid,
    input  rd_en,
    input  rd_addr,
    input  rd_buf,
    input  wr_en,
    input  wr_addr,
    input  wr_buf,
    input  new_acc
  );

  modport slave (
    input  sync,
    input  din_valid,
    output rd_en,
    output rd_addr,
    output rd_buf,
    output wr_en,
    output wr_addr,
    output wr_buf,
    output new_acc
  );
endinterface

// File: rtl/vacc_ctrl.sv
// Read-modify-write sequencer for a double-buffered vector accumulator.
// Reads old sums, replays each read as a write RAM_LATENCY cycles later.
module vacc_ctrl #(
  parameter int VECTOR_LENGTH = 32,
  parameter int ACC_LEN_BITS  = 8,
  parameter int RAM_LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vacc_if.slave                   bus,
  output logic                    acc_done,
  output logic                    buf_sel,
  output logic [ACC_LEN_BITS-1:0] vec_cnt,
  output logic                    busy,
  output logic                    sync_err
);
  localparam int VLB = $clog2(VECTOR_LENGTH);

  if (RAM_LATENCY < 1 ||
      RAM_LATENCY >= VECTOR_LENGTH - 1) begin : g_bad_lat
    $error("vacc_ctrl: RAM_LATENCY must be in 1..VECTOR_LENGTH-2");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef struct packed {
    logic           en;
    logic [VLB-1:0] addr;
    logic           bsel;
    logic           first;
    logic           last;
  } wr_t;

  state_t         state;
  logic [VLB-1:0] elem_cnt;
  logic           fill_buf;
  wr_t            pipe [RAM_LATENCY];
  wr_t            rd;
  wr_t            wo;
  logic           run;
  logic           elem_wrap;
  logic           vec_wrap;

  always_comb begin
    run       = (state == RUN);
    elem_wrap = (elem_cnt == VLB'(VECTOR_LENGTH - 1));
    vec_wrap  = (vec_cnt == '1);
    rd.en     = bus.din_valid & (run | bus.sync);
    rd.addr   = bus.sync ? '0 : elem_cnt;
    rd.bsel   = bus.sync ? 1'b0 : fill_buf;
    rd.first  = bus.sync | (vec_cnt == '0);
    // Only a sync-free read can close an integration.
    rd.last   = ~bus.sync & elem_wrap & vec_wrap;
    sync_err  = run & bus.sync & (elem_cnt != '0);
    wo        = pipe[RAM_LATENCY-1];
  end

  assign bus.rd_en   = rd.en;
  assign bus.rd_addr = rd.addr;
  assign bus.rd_buf  = rd.bsel;
  assign bus.wr_en   = wo.en;
  assign bus.wr_addr = wo.addr;
  assign bus.wr_buf  = wo.bsel;
  assign bus.new_acc = wo.en & wo.first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      elem_cnt <= '0;
      vec_cnt  <= '0;
      fill_buf <= 1'b0;
      buf_sel  <= 1'b1;
      acc_done <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= rd;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      acc_done <= wo.en & wo.last;
      if (wo.en & wo.last) begin
        buf_sel <= wo.bsel;
      end
      if (bus.sync) begin
        state    <= RUN;
        busy     <= 1'b1;
        vec_cnt  <= '0;
        elem_cnt <= bus.din_valid ? VLB'(1) : '0;
      end else if (rd.en) begin
        elem_cnt <= elem_cnt + 1'b1;
        if (elem_wrap) begin
          vec_cnt <= vec_cnt + 1'b1;
          if (vec_wrap) begin
            fill_buf <= ~fill_buf;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_vacc_ctrl.sv
// Scoreboard bench for vacc_ctrl: stimulus queues expected writes and
// completions, a negedge monitor pops and compares them.
module tb_vacc_ctrl;
  localparam int VL  = 4;
  localparam int AB  = 2;
  localparam int RL  = 2;
  localparam int VLB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acc_done;
  logic          buf_sel;
  logic          busy;
  logic          sync_err;
  logic [AB-1:0] vec_cnt;

  always #5 clk = ~clk;

  vacc_if #(.VLB(VLB)) bus ();

  vacc_ctrl #(
    .VECTOR_LENGTH(VL),
    .ACC_LEN_BITS (AB),
    .RAM_LATENCY  (RL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .acc_done(acc_done),
    .buf_sel (buf_sel),
    .vec_cnt (vec_cnt),
    .busy    (busy),
    .sync_err(sync_err)
  );

  typedef struct {
    int c;
    int addr;
    int bsel;
    int nw;
  } wexp_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  wexp_t wr_q[$];
  int    done_q[$];
  int    dbuf_q[$];
  wexp_t w_m;
  int    d_m;
  int    b_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          w_m = wr_q.pop_front();
          chk("wr_cycle", cyc, w_m.c);
          chk("wr_addr", bus.wr_addr, w_m.addr);
          chk("wr_buf", bus.wr_buf, w_m.bsel);
          chk("new_acc", bus.new_acc, w_m.nw);
        end
      end else begin
        chk("new_acc_idle", bus.new_acc, 0);
      end
      if (acc_done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          d_m = done_q.pop_front();
          b_m = dbuf_q.pop_front();
          chk("done_cycle", cyc, d_m);
          chk("done_buf_sel", buf_sel, b_m);
        end
      end
    end
  end

  task automatic step(input logic sy, input logic dv, input logic en,
                      input int addr, input int bsel, input int nw,
                      input int err);
    bus.sync      = sy;
    bus.din_valid = dv;
    @(negedge clk);
    chk("rd_en", bus.rd_en, en);
    chk("sync_err", sync_err, err);
    if (en) begin
      chk("rd_addr", bus.rd_addr, addr);
      chk("rd_buf", bus.rd_buf, bsel);
      wr_q.push_back('{cyc + RL, addr, bsel, nw});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b1;
    wr_q.delete();
    done_q.delete();
    dbuf_q.delete();
    #1;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_new_acc", bus.new_acc, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buf_sel", buf_sel, 1);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_acc_done", acc_done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b1;
    bus.sync      = 1'b0;
    bus.din_valid = 1'b0;
    #1;
    do_reset();

    repeat (4) begin
      step(0, 1, 0, 0, 0, 0, 0);
      chk("idle_busy", busy, 0);
      chk("idle_buf_sel", buf_sel, 1);
    end

    for (int i = 0; i < 20; i++) begin
      if (i == 15) begin
        done_q.push_back(cyc + 3);
        dbuf_q.push_back(0);
      end
      chk("run_vec_cnt", vec_cnt, (i / 4) % 4);
      step(i == 0, 1, 1, i % 4, int'(i >= 16),
           int'(i < 4 || i >= 16), 0);
      chk("run_busy", busy, 1);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("run_vec_cnt_end", vec_cnt, 1);
    chk("run_buf_sel_end", buf_sel, 0);

    step(0, 1, 1, 0, 1, 0, 0);
    do_reset();

    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        done_q.push_back(cyc + 3);
        dbuf_q.push_back(0);
      end
      step(k == 0, 1, 1, k % 4, 0, int'(k < 4), 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("gap_buf_sel", buf_sel, 0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      step(i == 0, 1, 1, i % 4, 0, int'(i < 4), 0);
    end
    chk("mid_vec_cnt_pre", vec_cnt, 1);
    step(1, 1, 1, 0, 0, 1, 1);
    chk("mid_vec_cnt_post", vec_cnt, 0);
    for (int i = 1; i < 4; i++) begin
      step(0, 1, 1, i, 0, 1, 0);
    end
    chk("mid_vec_cnt_next", vec_cnt, 1);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);

    chk("wr_q_drained", wr_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vacc_ctrl.md
Name: vacc_ctrl

Overview:
- Sequencer for the double-buffered vector accumulator built on a dual-port BRAM: read port A for the old partial sum, write port for the new sum.
- Issues read addresses, delays them by the BRAM read latency, and issues write addresses and enables for read-modify-write.
- Flags the first vector of each integration and counts vectors. Swaps the fill/readout buffer after every ACC_LEN vectors.
- Sits between the input data-valid stream and the vacc datapath/BRAM; also drives the buffer select used by readout.

Parameters:
VECTOR_LENGTH, 32, elements per vector; power of 2; VLB = log2(VECTOR_LENGTH)
ACC_LEN_BITS, 8, log2 of vectors per integration; ACC_LEN = 1<<ACC_LEN_BITS
RAM_LATENCY, 2, BRAM read latency in cycles (2 with output register enabled); must be less than VECTOR_LENGTH-1 (elaboration error otherwise)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sync  in  1  start new integration; qualifies a same-cycle din_valid as element 0
din_valid  in  1  one input vector element present this cycle
rd_en  out  1  BRAM read enable (old partial sum)
rd_addr  out  VLB  read element address
rd_buf  out  1  read buffer index (BRAM address MSB)
wr_en  out  1  BRAM write enable for accumulated sum
wr_addr  out  VLB  write element address
wr_buf  out  1  write buffer index
new_acc  out  1  aligned with wr_en; datapath writes din+0 (ignores old sum)
acc_done  out  1  one-cycle pulse, integration complete
buf_sel  out  1  buffer holding last completed integration (readout side)
vec_cnt  out  ACC_LEN_BITS  index of vector currently being read
busy  out  1  high in RUN
sync_err  out  1  one-cycle pulse, sync arrived mid-vector

Behaviour:
- Reset (async assert, sync deassert): state IDLE; elem_cnt=0, vec_cnt=0, fill_buf=0, buf_sel=1. All enables, pulses, rd_addr, wr_addr, new_acc and busy are 0. Delay pipeline cleared; in-flight writes dropped.
- States:
  - IDLE: din_valid ignored; sync -> RUN.
  - RUN: stays in RUN; continuous integrations, no return to IDLE except by reset.
- Read side, combinational from state and counters: rd_en = din_valid & (RUN | sync). rd_addr = elem_cnt, rd_buf = fill_buf, both 0 when sync is high.
- On each accepted element, elem_cnt increments modulo VECTOR_LENGTH.
- On elem_cnt wrap, vec_cnt increments modulo ACC_LEN.
- When vec_cnt wraps (last element of vector ACC_LEN-1 read): fill_buf toggles for the next read.
- Write side: the tuple {rd_en, rd_addr, rd_buf, first-vector flag} passes through a RAM_LATENCY-stage register pipeline. wr_en/wr_addr/wr_buf/new_acc are its outputs, exactly RAM_LATENCY cycles after the corresponding read.
- new_acc = 1 for every write of vector 0 of an integration.
- acc_done: pulses the cycle after the last write of vector ACC_LEN-1. buf_sel <= that write's wr_buf on the same edge.
- Gaps in din_valid stall the counters only; the pipeline keeps advancing.
- sync in RUN:
  - elem_cnt==0: clean restart. vec_cnt=0, same fill_buf, no error.
  - elem_cnt!=0: sync_err pulse, then restart as above. The partial vector is abandoned; its in-flight writes still complete.
- Hazard-free by the parameter constraint: an address is never re-read before its prior write.

Test Plan:
(VECTOR_LENGTH=4, ACC_LEN_BITS=2, RAM_LATENCY=2 unless stated)
- Reset, then din_valid high with no sync -> rd_en=0, wr_en=0, busy=0, buf_sel=1 throughout.
- sync+din_valid at cycle 0, din_valid continuous for 20 cycles:
  - reads: rd_addr 0,1,2,3 repeating; rd_buf=0 for cycles 0-15, 1 from cycle 16.
  - writes: wr_en cycles 2-21; new_acc high at cycles 2-5 and again at 18-21.
  - completion: acc_done pulse at cycle 18, buf_sel=0 from cycle 18.
- din_valid every other cycle after sync -> each wr_en occurs exactly 2 cycles after its rd_en with the same address; acc_done after the 16th write +1 cycle.
- Mid-vector sync:
  - sync at elem_cnt=2, vec_cnt=1 with din_valid -> sync_err pulse; rd_addr=0 that cycle; vec_cnt=0.
  - The next 4 writes carry new_acc=1; the 2 earlier in-flight writes still occur with new_acc=0.
- rst_n low 1 cycle after a read (write pending) -> wr_en stays 0, all outputs at reset values immediately, busy=0; next sync restarts with rd_buf=0.
- RAM_LATENCY=3, VECTOR_LENGTH=4 -> elaboration error; RAM_LATENCY=3, VECTOR_LENGTH=8 -> write lag exactly 3 cycles.
